unary_skew_feeder: RTL and testbench
====================================

# unary_skew_feeder

Converts rows of binary operands into skewed, multi-bit-per-cycle unary (thermometer) streams for the unary systolic array. It accepts one DIM-wide row per valid/ready handshake and double-buffers rows so streaming runs back-to-back. Optionally, it applies the diagonal systolic skew (lane i delayed i cycles). It sits between the operand row buffer and the array's west edge, and signals tile completion.

## Interface
- DIM, 8: lanes (array rows); ≥2.
- BWIDTH, 4: binary operand width; max value V = 2^BWIDTH−1.
- UWIDTH, 2: unary bits emitted per lane per cycle; 1 ≤ UWIDTH ≤ V.
- SKEW, 1: 1 = lane i delayed i cycles; 0 = all lanes aligned.

- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- clear  in  1  sync flush of buffers, counters, skew lines.
- in_valid  in  1  row_in holds a row.
- in_ready  out  1  feeder can accept a row.
- row_in  in  [DIM][BWIDTH]  binary operands, lane-indexed.
- in_last  in  1  row is last of tile; sampled with handshake.
- syst_arr_in  out  [DIM][UWIDTH]  unary bits per lane.
- lane_valid  out  [DIM]  syst_arr_in[i] carries stream data.
- busy  out  1  any row buffered or in flight.
- done  out  1  1-cycle pulse: last row of tile fully drained.

## Operation
- Window P = ceil(V/UWIDTH) cycles per row (defaults: P=8). Window counter k counts 0..P−1.
- Encoding: during window cycle k, lane i bit j = ((k·UWIDTH + j) < value_i). Ones come first. Total ones = value_i. Padding bits beyond V are 0.
- Row buffer has 2 entries: active (streaming) and pending.
  - Accept when in_valid && in_ready.
  - in_ready = ~pending_full && ~clear. It is registered-state only, with no combinational path from in_valid.
- When active finishes (k=P−1) and pending is full, pending→active and the next window starts the following cycle with no bubble.
  - If pending is empty, active empties.
  - If buffers are empty, an accepted row goes straight to active.
- in_last travels with its row. When the tagged row's last skewed lane (lane DIM−1 if SKEW, any lane if not) finishes its window, done pulses the next cycle.
- Skew: per-lane delay line of depth i (SKEW=1) on {bits, valid, last}. Depth 0 for all lanes when SKEW=0.
- clear: synchronous, highest priority. It empties buffers, zeroes k and delay lines, and suppresses done. A row presented in the same cycle is not accepted.
- value 0: lane_valid high for P cycles with all-zero bits. value V: V ones then padding zeros.

## Timing
- All outputs registered. Reset/clear values: syst_arr_in=0, lane_valid=0, in_ready=1 (0 while clear high), busy=0, done=0.
- Latency: handshake at edge t (straight to active) → lane 0 first window cycle visible at t+1, lane i at t+1+i (SKEW=1).
- Throughput: one row per P cycles sustained. in_ready stays high while pending is empty.
- Simultaneous accept and active completion with pending empty: the new row becomes active at the window boundary, gapless.
- Simultaneous accept and active completion with pending full is impossible because in_ready is low.
- busy stays high until the last delay line drains. It falls the same cycle done rises.
- Reset mid-stream: all state is cleared asynchronously. No done pulse is generated.

## Structure
- Package unary_pkg:
  - function ceil_div.
  - localparams for P and counter width $clog2(P) (min 1).
  - row buffer entry typedef {values [DIM][BWIDTH], last}.
- Sub-module skew_line #(DEPTH, WIDTH): shift register, pass-through at DEPTH=0, clear input. One instance per lane via generate.
- Top level holds buffer control, window counter, unary comparators, and done logic.

## Test plan
- Single row, defaults, SKEW=1, row_in all lanes =5, in_last=1:
  - lane i shows bits 11,11,01,00,00,00,00,00 over cycles t+1+i..t+8+i (bit j=0 listed right).
  - done pulses at t+16.
- Boundary values, lanes {0,15,1,14,7,8,2,13}:
  - per-lane ones count over the window equals value.
  - lane 1 ends 01 in the final cycle.
  - lane 0 is valid and all-zero.
- Back-to-back 4-row tile with in_valid held:
  - lane 0 lane_valid is continuous for 32 cycles.
  - in_ready drops only while pending is full.
  - exactly one done, after row 4.
- SKEW=0, UWIDTH=1, BWIDTH=3: P=7. Value 3 → 1110000 on all lanes simultaneously.
- clear in mid-window of row 2 with a row pending:
  - next cycle outputs are zero and busy=0.
  - no done.
  - a row offered during clear is not accepted.
- Async reset_n asserted mid-stream and released: all outputs zero immediately, and the next tile streams correctly from k=0.

Source files
------------

// File: rtl/unary_pkg.sv
// Shared helpers and default sizing for the unary skew feeder.
package unary_pkg;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_DIM    = 8;
    localparam int unsigned DEF_BWIDTH = 4;
    localparam int unsigned DEF_UWIDTH = 2;
    localparam int unsigned DEF_P      = ceil_div((1 << DEF_BWIDTH) - 1, DEF_UWIDTH);
    localparam int unsigned DEF_CNT_W  = cnt_width(DEF_P);

    typedef struct packed {
        logic [DEF_DIM-1:0][DEF_BWIDTH-1:0] values;
        logic                               last;
    } row_entry_t;

endpackage

// File: rtl/skew_line.sv
// Per-lane delay line with synchronous flush; DEPTH=0 is a plain wire.
module skew_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{clk, reset_n, clear};
        assign dout      = din;
    end else begin : g_shift
        logic [DEPTH-1:0][WIDTH-1:0] sr_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sr_q <= '0;
            end else if (clear) begin
                sr_q <= '0;
            end else begin
                sr_q[0] <= din;
                for (int d = 1; d < DEPTH; d++) begin
                    sr_q[d] <= sr_q[d-1];
                end
            end
        end

        assign dout = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/unary_skew_feeder.sv
// Double-buffered binary rows streamed as skewed thermometer codes to the array's west edge.
module unary_skew_feeder
    import unary_pkg::*;
#(
    parameter int unsigned DIM    = 8,
    parameter int unsigned BWIDTH = 4,
    parameter int unsigned UWIDTH = 2,
    parameter int unsigned SKEW   = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DIM-1:0][BWIDTH-1:0]   row_in,
    input  logic                         in_last,
    output logic [DIM-1:0][UWIDTH-1:0]   syst_arr_in,
    output logic [DIM-1:0]               lane_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned V     = (1 << BWIDTH) - 1;
    localparam int unsigned P     = ceil_div(V, UWIDTH);
    localparam int unsigned CNT_W = cnt_width(P);
    localparam int unsigned LW    = UWIDTH + 2;
    localparam int unsigned DRAIN = (SKEW != 0) ? DIM : 1;
    localparam int unsigned DRN_W = $clog2(DIM + 1);
    localparam logic [DIM-1:0] LAST_MASK =
        (SKEW != 0) ? {1'b1, {(DIM-1){1'b0}}} : {DIM{1'b1}};

    typedef struct packed {
        logic [DIM-1:0][BWIDTH-1:0] values;
        logic                       last;
    } row_t;

    row_t                   act_q, act_d, pend_q, pend_d;
    logic                   act_full_q, act_full_d, pend_full_q, pend_full_d;
    logic [CNT_W-1:0]       k_q, k_d;
    logic [DRN_W-1:0]       drain_q, drain_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic [DIM-1:0][LW-1:0] s0_q, s0_d, lane_out;
    logic [DIM-1:0]         last_vec;
    logic                   accept, win_end;

    assign in_ready = ~pend_full_q & ~clear;
    assign accept   = in_valid & in_ready;
    assign win_end  = act_full_q && (k_q == CNT_W'(P - 1));

    always_comb begin
        act_d       = act_q;
        pend_d      = pend_q;
        act_full_d  = act_full_q;
        pend_full_d = pend_full_q;
        k_d         = k_q;
        drain_d     = (drain_q != '0) ? drain_q - 1'b1 : '0;
        if (clear) begin
            act_full_d  = 1'b0;
            pend_full_d = 1'b0;
            k_d         = '0;
            drain_d     = '0;
        end else if (!act_full_q) begin
            if (accept) begin
                act_d      = {row_in, in_last};
                act_full_d = 1'b1;
                k_d        = '0;
            end
        end else if (win_end) begin
            k_d = '0;
            if (pend_full_q) begin
                act_d       = pend_q;
                pend_full_d = 1'b0;
            end else if (accept) begin
                act_d = {row_in, in_last};
            end else begin
                act_full_d = 1'b0;
                // keep busy asserted until the slowest delay line has emptied
                drain_d    = DRN_W'(DRAIN);
            end
        end else begin
            k_d = k_q + 1'b1;
            if (accept) begin
                pend_d      = {row_in, in_last};
                pend_full_d = 1'b1;
            end
        end
        busy_d = act_full_d | pend_full_d | (drain_d != '0);
    end

    always_comb begin
        s0_d = '0;
        if (act_full_q && !clear) begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < UWIDTH; j++) begin
                    s0_d[i][j] = (32'(k_q) * UWIDTH + 32'(j)) < 32'(act_q.values[i]);
                end
                s0_d[i][UWIDTH]   = 1'b1;
                s0_d[i][UWIDTH+1] = act_q.last & win_end;
            end
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        skew_line #(
            .DEPTH ((SKEW != 0) ? i : 0),
            .WIDTH (LW)
        ) u_skew (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (clear),
            .din     (s0_q[i]),
            .dout    (lane_out[i])
        );
        assign syst_arr_in[i] = lane_out[i][UWIDTH-1:0];
        assign lane_valid[i]  = lane_out[i][UWIDTH];
        assign last_vec[i]    = lane_out[i][UWIDTH+1];
    end

    assign done_d = ~clear & (|(last_vec & LAST_MASK));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q       <= '0;
            pend_q      <= '0;
            act_full_q  <= 1'b0;
            pend_full_q <= 1'b0;
            k_q         <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s0_q        <= '0;
        end else begin
            act_q       <= act_d;
            pend_q      <= pend_d;
            act_full_q  <= act_full_d;
            pend_full_q <= pend_full_d;
            k_q         <= k_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            s0_q        <= s0_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_unary_skew_feeder.sv
// Bench for unary_skew_feeder: directed and random rows checked against a window-schedule model.
module tb_unary_skew_feeder;
    localparam int DIM  = 8;
    localparam int BW   = 4;
    localparam int UW   = 2;
    localparam int P    = 8;
    localparam int DMAX = DIM - 1;
    localparam int MAXR = 512;

    logic clk = 1'b0;
    logic reset_n, clear, in_valid, in_last, in_ready, busy, done;
    logic [DIM-1:0][BW-1:0] row_in;
    logic [DIM-1:0][UW-1:0] syst_arr_in;
    logic [DIM-1:0]         lane_valid;

    logic clear7, in_valid7, in_last7, in_ready7, busy7, done7;
    logic [DIM-1:0][2:0] row7;
    logic [DIM-1:0][0:0] arr7;
    logic [DIM-1:0]      lv7;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_rows = 0, first_live = 0, next_free = 0;
    int r_start[MAXR];
    bit r_last[MAXR];
    int r_val[MAXR][DIM];

    always #5 clk = ~clk;

    unary_skew_feeder dut (
        .clk (clk), .reset_n (reset_n), .clear (clear), .in_valid (in_valid),
        .in_ready (in_ready), .row_in (row_in), .in_last (in_last),
        .syst_arr_in (syst_arr_in), .lane_valid (lane_valid), .busy (busy), .done (done)
    );

    unary_skew_feeder #(.DIM (DIM), .BWIDTH (3), .UWIDTH (1), .SKEW (0)) dut7 (
        .clk (clk), .reset_n (reset_n), .clear (clear7), .in_valid (in_valid7),
        .in_ready (in_ready7), .row_in (row7), .in_last (in_last7),
        .syst_arr_in (arr7), .lane_valid (lv7), .busy (busy7), .done (done7)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Buffer occupancy after edge n: a row holds a slot from acceptance to its last window cycle.
    function automatic bit model_ready(input int n);
        int cnt = 0;
        for (int r = first_live; r < n_rows; r++)
            if (n <= r_start[r] + P - 2) cnt++;
        return cnt < 2;
    endfunction

    task automatic check_all();
        logic [DIM-1:0][UW-1:0] e_bits;
        logic [DIM-1:0]         e_val;
        logic                   e_busy, e_done;
        e_bits = '0; e_val = '0; e_busy = 1'b0; e_done = 1'b0;
        for (int r = first_live; r < n_rows; r++) begin
            for (int i = 0; i < DIM; i++) begin
                int k;
                k = cyc - r_start[r] - i;
                if (k >= 0 && k < P) begin
                    e_val[i] = 1'b1;
                    for (int j = 0; j < UW; j++) e_bits[i][j] = (k * UW + j) < r_val[r][i];
                end
            end
            if (cyc < r_start[r] + P + DMAX) e_busy = 1'b1;
            if (r_last[r] && cyc == r_start[r] + P + DMAX) e_done = 1'b1;
        end
        chk("bits", syst_arr_in, e_bits);
        chk("lane_valid", lane_valid, e_val);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("in_ready", in_ready, model_ready(cyc) && !clear);
    endtask

    task automatic tick();
        bit rdy;
        rdy = model_ready(cyc) && !clear && reset_n;
        @(posedge clk);
        cyc++;
        if (!reset_n || clear) begin
            first_live = n_rows;
            next_free  = 0;
        end else if (in_valid && rdy) begin
            int s;
            s = (cyc + 1 > next_free) ? cyc + 1 : next_free;
            r_start[n_rows] = s;
            r_last[n_rows]  = in_last;
            for (int i = 0; i < DIM; i++) r_val[n_rows][i] = int'(row_in[i]);
            next_free = s + P;
            n_rows++;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_row();
        for (int i = 0; i < DIM; i++) row_in[i] = BW'($urandom_range(15));
    endtask

    initial begin
        int t, acc, run, maxrun, dn, base;
        int ones[DIM];
        logic [7:0] e7;
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; row_in = '0;
        clear7 = 1'b0; in_valid7 = 1'b0; in_last7 = 1'b0; row7 = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Single row of 5s with last: lane i shows 11,11,01,00... from t+1+i; done at t+16.
        for (int i = 0; i < DIM; i++) row_in[i] = 4'd5;
        in_valid = 1'b1; in_last = 1'b1;
        tick();
        t = cyc; in_valid = 1'b0; in_last = 1'b0;
        tick(); tick(); tick();
        chk("five_lane0_k2", syst_arr_in[0], 2'b01);
        repeat (12) tick();
        chk("five_done_pre", done, 1'b0);
        tick();
        chk("five_done_at_t16", cyc - t, 16);
        chk("five_done", done, 1'b1);
        tick();

        // Boundary values: per-lane ones count equals the operand.
        row_in = {4'd13, 4'd2, 4'd8, 4'd7, 4'd14, 4'd1, 4'd15, 4'd0};
        in_valid = 1'b1; in_last = 1'b1;
        for (int i = 0; i < DIM; i++) ones[i] = 0;
        tick();
        t = cyc; in_valid = 1'b0; in_last = 1'b0;
        for (int c = 0; c < 18; c++) begin
            tick();
            if (cyc == t + 9) chk("lane1_final", syst_arr_in[1], 2'b01);
            for (int i = 0; i < DIM; i++) if (lane_valid[i]) ones[i] += $countones(syst_arr_in[i]);
        end
        chk("ones0", ones[0], 0);   chk("ones1", ones[1], 15);
        chk("ones2", ones[2], 1);   chk("ones3", ones[3], 14);
        chk("ones4", ones[4], 7);   chk("ones5", ones[5], 8);
        chk("ones6", ones[6], 2);   chk("ones7", ones[7], 13);

        // Back-to-back 4-row tile with in_valid held.
        acc = 0; run = 0; maxrun = 0; dn = 0; base = n_rows;
        rand_row(); in_valid = 1'b1; in_last = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (lane_valid[0]) run++;
            else begin if (run > maxrun) maxrun = run; run = 0; end
            if (done) dn++;
            if (n_rows - base != acc) begin
                acc = n_rows - base;
                rand_row();
                in_last  = (acc == 3);
                in_valid = (acc < 4);
            end
        end
        chk("b2b_accepted", acc, 4);
        chk("b2b_lane0_run", maxrun, 32);
        chk("b2b_one_done", dn, 1);

        // Randomised traffic with occasional flush.
        for (int c = 0; c < 400; c++) begin
            rand_row();
            in_valid = ($urandom_range(1) == 0);
            in_last  = ($urandom_range(3) == 0);
            clear    = ($urandom_range(39) == 0);
            tick();
        end
        in_valid = 1'b0; clear = 1'b0;
        repeat (20) tick();

        // Flush mid-window of row 2 while row 3 is pending.
        base = n_rows; acc = 0;
        rand_row(); in_valid = 1'b1; in_last = 1'b0;
        for (int c = 0; c < 40 && acc < 3; c++) begin
            tick();
            if (n_rows - base != acc) begin acc = n_rows - base; rand_row(); in_last = 1'b1; end
        end
        chk("clr_rows_queued", acc, 3);
        in_valid = 1'b0;
        repeat (3) tick();
        clear = 1'b1; in_valid = 1'b1; rand_row();
        tick();
        chk("clr_lane_valid", lane_valid, '0);
        chk("clr_bits", syst_arr_in, '0);
        chk("clr_busy", busy, 1'b0);
        chk("clr_ready", in_ready, 1'b0);
        clear = 1'b0; in_valid = 1'b0; dn = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done || lane_valid != '0) dn++;
        end
        chk("clr_quiet", dn, 0);

        // Aligned narrow config: value 3 gives 1110000 on every lane at once.
        for (int i = 0; i < DIM; i++) row7[i] = 3'd3;
        in_valid7 = 1'b1; in_last7 = 1'b1;
        tick();
        in_valid7 = 1'b0; in_last7 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            e7 = (k < 3) ? 8'hFF : 8'h00;
            chk("p7_bits", arr7, e7);
            chk("p7_valid", lv7, 8'hFF);
        end
        tick();
        chk("p7_done", done7, 1'b1);
        chk("p7_busy", busy7, 1'b0);

        // Asynchronous reset mid-stream, then a fresh tile.
        rand_row(); in_valid = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        chk("rst_lane_valid", lane_valid, '0);
        chk("rst_bits", syst_arr_in, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        rand_row(); in_valid = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0; dn = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done) dn++;
        end
        chk("rst_tile_done", dn, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
